// File: rtl/tessiax32_store_buffer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tessiax32_pkg                                                        |
// | Shared widths, entry record and drain-FSM states for the store buffer|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package tessiax32_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_t;

endpackage
`default_nettype wire

// File: rtl/tessiax32_store_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tessiax32_store_buffer_if                                            |
// | Core store/load port, memory write port and fence handshake          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface tessiax32_store_buffer_if #(
    parameter int DEPTH = 4
);
    import tessiax32_pkg::*;

    logic                     StoreValid;
    logic [ADDR_W-1:0]        StoreAddress;
    logic [DATA_W-1:0]        StoreData;
    logic                     StoreReady;
    logic [ADDR_W-1:0]        LoadAddress;
    logic                     LoadHit;
    logic [DATA_W-1:0]        LoadData;
    logic                     MemWriteEnable;
    logic [ADDR_W-1:0]        MemAddress;
    logic [DATA_W-1:0]        MemWriteData;
    logic                     MemWriteAck;
    logic                     Fence;
    logic                     FenceDone;
    logic [$clog2(DEPTH):0]   Count;

    // Core / memory side that drives the buffer
    modport master (
        output StoreValid, StoreAddress, StoreData, LoadAddress, MemWriteAck, Fence,
        input  StoreReady, LoadHit, LoadData, MemWriteEnable, MemAddress, MemWriteData,
        input  FenceDone, Count
    );

    // The buffer itself
    modport slave (
        input  StoreValid, StoreAddress, StoreData, LoadAddress, MemWriteAck, Fence,
        output StoreReady, LoadHit, LoadData, MemWriteEnable, MemAddress, MemWriteData,
        output FenceDone, Count
    );

endinterface
`default_nettype wire

// File: rtl/tessiax32_store_buffer_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tessiax32_sb_match                                                   |
// | Youngest-match selector: scans back from wrPtr-1 to the head entry   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tessiax32_sb_match
    import tessiax32_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PTR_W    = $clog2(DEPTH),
    parameter int MATCH_AW = ADDR_W
) (
    input  logic [DEPTH-1:0]    i_valid,
    input  logic [MATCH_AW-1:0] i_addrs [DEPTH],
    input  logic [PTR_W-1:0]    i_rdPtr,
    input  logic [PTR_W-1:0]    i_wrPtr,
    input  logic [MATCH_AW-1:0] i_loadAddress,
    output logic                o_hit,
    output logic [PTR_W-1:0]    o_idx
);

    logic [PTR_W-1:0] w_scan;
    logic             w_stop;

    // The head entry (rdPtr) is the oldest slot, so the scan ends there.
    always_comb begin
        o_hit  = 1'b0;
        o_idx  = '0;
        w_stop = 1'b0;
        w_scan = i_wrPtr;
        for (int k = 1; k <= DEPTH; k++) begin
            w_scan = i_wrPtr - PTR_W'(k);
            if (!w_stop && !o_hit && i_valid[w_scan] && (i_addrs[w_scan] == i_loadAddress)) begin
                o_hit = 1'b1;
                o_idx = w_scan;
            end
            if (w_scan == i_rdPtr) begin
                w_stop = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tessiax32_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tessiax32_store_buffer                                               |
// | In-order posted-write buffer with load forwarding and fence drain    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tessiax32_store_buffer
    import tessiax32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    tessiax32_store_buffer_if.slave  sb
);

    localparam int         c_PTR_W = $clog2(DEPTH);
    localparam int         c_CNT_W = c_PTR_W + 1;
    localparam logic [0:0] c_IDLE  = SB_IDLE;
    localparam logic [0:0] c_DRAIN = SB_DRAIN;

    sb_entry_t            r_entries [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [c_PTR_W-1:0]   r_wrPtr;
    logic [c_PTR_W-1:0]   r_rdPtr;
    logic [c_CNT_W-1:0]   r_count;
    logic [0:0]           r_state;
    logic                 r_fenceArmed;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hit;
    logic [c_PTR_W-1:0]   w_hitIdx;
    logic [ADDR_W-1:0]    w_addrs [DEPTH];

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = sb.StoreValid && sb.StoreReady;
    assign w_pop   = sb.MemWriteEnable && sb.MemWriteAck;

    // Readiness ignores MemWriteAck so a full buffer never accepts in the pop cycle.
    assign sb.StoreReady     = !w_full && (r_state == c_IDLE) && reset;
    assign sb.MemWriteEnable = !w_empty;
    assign sb.MemAddress     = w_empty ? '0 : r_entries[r_rdPtr].addr;
    assign sb.MemWriteData   = w_empty ? '0 : r_entries[r_rdPtr].data;
    assign sb.FenceDone      = (r_state == c_DRAIN) && w_empty;
    assign sb.Count          = r_count;
    assign sb.LoadHit        = w_hit;
    assign sb.LoadData       = w_hit ? r_entries[w_hitIdx].data : '0;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_addrs
            assign w_addrs[i] = r_entries[i].addr;
        end
    endgenerate

    tessiax32_sb_match #(
        .DEPTH    (DEPTH),
        .PTR_W    (c_PTR_W),
        .MATCH_AW (ADDR_W)
    ) u_match (
        .i_valid       (r_valid),
        .i_addrs       (w_addrs),
        .i_rdPtr       (r_rdPtr),
        .i_wrPtr       (r_wrPtr),
        .i_loadAddress (sb.LoadAddress),
        .o_hit         (w_hit),
        .o_idx         (w_hitIdx)
    );

    // Payload storage carries no reset; valid bits and count qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_wrPtr] <= '{addr: sb.StoreAddress, data: sb.StoreData};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= '0;
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Fence must drop for a cycle before it can start another drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_fenceArmed <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (sb.Fence && r_fenceArmed) begin
                        r_state      <= c_DRAIN;
                        r_fenceArmed <= 1'b0;
                    end else if (!sb.Fence) begin
                        r_fenceArmed <= 1'b1;
                    end
                end
                c_DRAIN: begin
                    if (w_empty) begin
                        r_state <= c_IDLE;
                    end
                    if (!sb.Fence) begin
                        r_fenceArmed <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
